keymgr_input_check_seq: RTL

// - Multi-channel, sequential input-validity checker for the key manager.
// - Handshake-started: on request, scans NumCh input channels one per cycle.
// - Flags each channel as valid only if it is neither all-zeros nor all-ones.
// - Repeats the scan Passes times; any channel whose result changes between

---
 rtl/keymgr_input_check_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/keymgr_input_check_seq.sv
// Sequential input-validity checker for the key manager.
// On request, scans NumCh data channels one per cycle, repeated Passes times.
// A channel is valid when it is neither all-zeros nor all-ones; any channel
// whose result changes between passes raises stable_err_o. The key version is
// checked against the per-stage maximum at accept time.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for req_i; results of the last request are held
// SCAN    | one channel per cycle, ch_idx 0..NumCh-1 per pass
// DONE    | ack_o pulse, all_vld_o valid; back to IDLE next cycle
module keymgr_input_check_seq #(
  parameter int unsigned NumCh     = 4,
  parameter int unsigned Width     = 256,
  parameter int unsigned Passes    = 2,
  parameter int unsigned NumStages = 4,
  parameter int unsigned VerWidth  = 32,
  localparam int unsigned SelW     = (NumStages > 1) ? $clog2(NumStages) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_i,
  output logic                          busy_o,
  output logic                          ack_o,
  input  logic [NumCh*Width-1:0]        data_i,
  input  logic [SelW-1:0]               stage_sel_i,
  input  logic [NumStages*VerWidth-1:0] max_key_versions_i,
  input  logic [VerWidth-1:0]           key_version_i,
  output logic [NumCh-1:0]              ch_vld_o,
  output logic                          key_version_vld_o,
  output logic                          all_vld_o,
  output logic                          stable_err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned ChW   = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned PassW = (Passes > 1) ? $clog2(Passes) : 1;
  localparam logic [ChW-1:0]   ChLast   = ChW'(NumCh - 1);
  localparam logic [PassW-1:0] PassLast = PassW'(Passes - 1);

  logic [1:0]       state;
  logic [ChW-1:0]   ch_idx;
  logic [PassW-1:0] pass;
  logic [NumCh-1:0] ch_vld;
  logic             kv_vld;
  logic             stable_err;

  logic             kv_next;
  logic             cur_vld;
  logic             old_vld;
  logic             legal;

  // Version check against the selected stage; out-of-range stages never match.
  always_comb begin
    kv_next = 1'b0;
    for (int s = 0; s < NumStages; s++) begin
      if (stage_sel_i == SelW'(s)) begin
        kv_next = (key_version_i <= max_key_versions_i[s*VerWidth +: VerWidth]);
      end
    end
  end

  // Validity of the channel currently addressed, and its pass-0 result.
  always_comb begin
    cur_vld = 1'b0;
    old_vld = 1'b0;
    for (int c = 0; c < NumCh; c++) begin
      if (ch_idx == ChW'(c)) begin
        cur_vld = (|data_i[c*Width +: Width]) & ~(&data_i[c*Width +: Width]);
        old_vld = ch_vld[c];
      end
    end
  end

  // Control FSM, scan counters and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      ch_idx     <= '0;
      pass       <= '0;
      ch_vld     <= '0;
      kv_vld     <= 1'b0;
      stable_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_i) begin
            kv_vld     <= kv_next;
            ch_vld     <= '0;
            stable_err <= 1'b0;
            ch_idx     <= '0;
            pass       <= '0;
            state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (pass == '0) begin
            for (int c = 0; c < NumCh; c++) begin
              if (ch_idx == ChW'(c)) ch_vld[c] <= cur_vld;
            end
          end else if (cur_vld != old_vld) begin
            stable_err <= 1'b1;
          end
          if (ch_idx == ChLast) begin
            ch_idx <= '0;
            if (pass == PassLast) begin
              pass  <= '0;
              state <= ST_DONE;
            end else begin
              pass <= pass + PassW'(1);
            end
          end else begin
            ch_idx <= ch_idx + ChW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          ch_idx     <= '0;
          pass       <= '0;
          ch_vld     <= '0;
          kv_vld     <= 1'b0;
          stable_err <= 1'b0;
        end
      endcase
    end
  end

  // Outputs; an illegal state forces everything low until recovery.
  always_comb begin
    legal             = (state == ST_IDLE) || (state == ST_SCAN) || (state == ST_DONE);
    busy_o            = (state == ST_SCAN) || (state == ST_DONE);
    ack_o             = (state == ST_DONE);
    ch_vld_o          = legal ? ch_vld : '0;
    key_version_vld_o = legal & kv_vld;
    stable_err_o      = legal & stable_err;
    all_vld_o         = ((state == ST_IDLE) || (state == ST_DONE)) &
                        (&ch_vld) & kv_vld & ~stable_err;
  end

endmodule
